matrix_scan_scheduler: RTL and testbench
========================================

// Module: matrix_scan_scheduler
// PURPOSE
//   Owns the 8x8 RGB LED matrix: double-buffered frame store plus the row-scan sequencer.
//   Game logic writes pixels into the back bank. Front/back swap happens only on request,
//   and only at a frame boundary. The scanner drives COMM and the active-low Data_R/G/B
//   column lines, with a blanking interval between rows to suppress ghosting.
// PARAMETERS
//   DIV_MAX      25123  scan tick every DIV_MAX+1 CLK cycles
//   BLANK_TICKS  1      ticks per row with all columns off (>=1)
//   SHOW_TICKS   4      ticks per row with the row driven (>=1)
//   COL_REVERSE  0      1: logical column c drives Data_x bit 7-c; 0: drives bit c
// PORTS
//   CLK          in   1  system clock, all logic on posedge
//   RST_N        in   1  asynchronous, active-low reset
//   wr_en        in   1  write one pixel of the back bank this cycle
//   wr_row       in   3  pixel row 0..7
//   wr_col       in   3  pixel column 0..7
//   wr_rgb       in   3  {r,g,b}; 1 = lit
//   clr_req      in   1  one-cycle pulse: clear the entire back bank to unlit
//   swap_req     in   1  level; hold high until swap_ack
//   swap_ack     out  1  one-CLK pulse: banks swapped this cycle
//   frame_start  out  1  one-CLK pulse at every frame boundary (COMM wraps 7->0)
//   COMM         out  3  row currently selected
//   E            out  1  1 = row driven (SHOW); 0 = blanking
//   Data_R/G/B   out  8  column drives, active-low (0 = LED on)
// BEHAVIOUR
//   Reset (async, RST_N=0)
//     Data_R/G/B=8'hFF, COMM=0, E=0, swap_ack=0, frame_start=0.
//     Both banks cleared; front bank index=0; state=BLANK; tick and dwell counters=0.
//   Tick generation
//     div counter runs 0..DIV_MAX and wraps; tick=1 for the one CLK where count==DIV_MAX.
//   FSM {BLANK, SHOW}; dwell counter advances on tick only
//     BLANK: Data_*=FF, E=0. After BLANK_TICKS ticks -> SHOW.
//       On the transition edge, register front[COMM] into Data_* (inverted, COL_REVERSE mapping), E=1.
//     SHOW: Data_* and E held stable; front bank is sampled only at BLANK->SHOW.
//       After SHOW_TICKS ticks -> BLANK, Data_*=FF, E=0, COMM=(COMM+1)%8 (3-bit wrap).
//   Row period = (BLANK_TICKS+SHOW_TICKS)*(DIV_MAX+1) CLK; frame period = 8x row period.
//   Frame boundary = the SHOW->BLANK edge with COMM==7
//     frame_start=1 for that one CLK.
//     If swap_req==1 on that edge: front index toggles, swap_ack=1 for that one CLK.
//     If swap_req is low on that edge: no swap, no ack; a request dropped early is simply lost.
//   Writes
//     Always target the back bank (~front), registered, visible after the next swap.
//     A write in the swap cycle lands in the pre-swap back bank, i.e. is displayed by that swap.
//     clr_req clears all 64 back-bank pixels in one cycle; clr_req beats wr_en in the same cycle.
//     Clear in the swap cycle applies to the pre-swap back bank.
//     Out-of-range is impossible (3-bit fields); wr_rgb=3'b000 erases a pixel.
//   swap_req held across several frames yields exactly one ack per frame boundary
//     (toggles every frame); the requester must drop swap_req the cycle after ack.
//   Reset mid-row or mid-swap: immediate return to reset values; pending request discarded.
// STRUCTURE
//   Package matrix_pkg:
//     ROWS=8, COLS=8
//     typedef struct packed {logic r,g,b;} rgb_t
//     typedef rgb_t [COLS-1:0] row_t
//     typedef enum logic {BLANK, SHOW} scan_state_t
//   Sub-module scan_tick_gen (DIV_MAX, CLK, RST_N -> tick).
//   Everything else (banks, FSM, column encode) is local to this module.
// TESTING  (DIV_MAX=3, BLANK_TICKS=1, SHOW_TICKS=2, COL_REVERSE=0)
//   1 Reset: after RST_N release -> Data_R/G/B=FF, COMM=0, E=0, no pulses.
//     First E=1 occurs 4 CLK after release.
//   2 Timing: free-run -> E high 8 CLK, low 4 CLK per row; COMM steps 0..7..0;
//     frame_start every 96 CLK.
//   3 Write (2,5,3'b100), then swap_req -> swap_ack coincides with a frame_start.
//     Next row-2 SHOW: Data_R=8'b11011111, Data_G=Data_B=FF; all other rows FF.
//   4 clr_req and wr_en (0,0,3'b111) same cycle, then swap -> every row shows FF on all colors.
//   5 swap_req raised then dropped before the boundary -> no swap_ack; displayed image unchanged.
//   6 RST_N low during SHOW of row 4 -> outputs FF, E=0, COMM=0 within the same cycle (async),
//     and both banks are blank after release.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types for the 8x8 RGB matrix scan scheduler.
package matrix_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  typedef rgb_t [COLS-1:0] row_t;

  typedef enum logic {BLANK, SHOW} scan_state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider; tick is high for the one CLK where the count sits at DIV_MAX.
module scan_tick_gen #(
  parameter int unsigned DIV_MAX = 25123
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int unsigned CntW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/matrix_scan_scheduler.sv
// Double-buffered 8x8 RGB frame store with blanked row-scan sequencer and
// frame-boundary bank swap.
module matrix_scan_scheduler
  import matrix_pkg::*;
#(
  parameter int unsigned DIV_MAX     = 25123,
  parameter int unsigned BLANK_TICKS = 1,
  parameter int unsigned SHOW_TICKS  = 4,
  parameter bit          COL_REVERSE = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_rgb,
  input  logic       clr_req,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [2:0] COMM,
  output logic       E,
  output logic [7:0] Data_R,
  output logic [7:0] Data_G,
  output logic [7:0] Data_B
);

  localparam int unsigned DwMax = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
  localparam int unsigned DwW   = $clog2(DwMax + 1);
  localparam logic [DwW-1:0] BlankLast = DwW'(BLANK_TICKS - 1);
  localparam logic [DwW-1:0] ShowLast  = DwW'(SHOW_TICKS - 1);

  logic tick;

  scan_tick_gen #(
    .DIV_MAX (DIV_MAX)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick)
  );

  scan_state_t    state_q, state_d;
  logic [DwW-1:0] dwell_q, dwell_d;
  logic [2:0]     comm_q, comm_d;
  logic           front_q, front_d;
  logic           e_q, e_d;
  logic           ack_q, ack_d;
  logic           fs_q, fs_d;
  logic [7:0]     dr_q, dr_d, dg_q, dg_d, db_q, db_d;
  row_t           bank_q [2][ROWS];
  row_t           bank_d [2][ROWS];
  row_t           cur_row;
  logic           back;

  assign back    = ~front_q;
  assign cur_row = bank_q[front_q][comm_q];

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    comm_d  = comm_q;
    front_d = front_q;
    e_d     = e_q;
    ack_d   = 1'b0;
    fs_d    = 1'b0;
    dr_d    = dr_q;
    dg_d    = dg_q;
    db_d    = db_q;
    bank_d  = bank_q;

    // Writes use the pre-swap back bank even in the swap cycle.
    if (clr_req) begin
      bank_d[back] = '{default: '0};
    end else if (wr_en) begin
      bank_d[back][wr_row][wr_col] = wr_rgb;
    end

    if (tick) begin
      unique case (state_q)
        BLANK: begin
          if (dwell_q == BlankLast) begin
            state_d = SHOW;
            dwell_d = '0;
            e_d     = 1'b1;
            for (int c = 0; c < COLS; c++) begin
              dr_d[COL_REVERSE ? COLS-1-c : c] = ~cur_row[c].r;
              dg_d[COL_REVERSE ? COLS-1-c : c] = ~cur_row[c].g;
              db_d[COL_REVERSE ? COLS-1-c : c] = ~cur_row[c].b;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        SHOW: begin
          if (dwell_q == ShowLast) begin
            state_d = BLANK;
            dwell_d = '0;
            e_d     = 1'b0;
            dr_d    = 8'hFF;
            dg_d    = 8'hFF;
            db_d    = 8'hFF;
            comm_d  = comm_q + 3'd1;
            if (comm_q == 3'd7) begin
              fs_d = 1'b1;
              if (swap_req) begin
                front_d = ~front_q;
                ack_d   = 1'b1;
              end
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= BLANK;
      dwell_q <= '0;
      comm_q  <= '0;
      front_q <= 1'b0;
      e_q     <= 1'b0;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
      dr_q    <= 8'hFF;
      dg_q    <= 8'hFF;
      db_q    <= 8'hFF;
      bank_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      comm_q  <= comm_d;
      front_q <= front_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
      fs_q    <= fs_d;
      dr_q    <= dr_d;
      dg_q    <= dg_d;
      db_q    <= db_d;
      bank_q  <= bank_d;
    end
  end

  assign COMM        = comm_q;
  assign E           = e_q;
  assign swap_ack    = ack_q;
  assign frame_start = fs_q;
  assign Data_R      = dr_q;
  assign Data_G      = dg_q;
  assign Data_B      = db_q;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Directed bench: per-cycle scan timing/pulse/image checks plus write, clear, swap and reset cases.
module tb_matrix_scan_scheduler;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [2:0] wr_col = '0;
  logic [2:0] wr_rgb = '0;
  logic       clr_req = 1'b0;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_start, E;
  logic [2:0] COMM;
  logic [7:0] Data_R, Data_G, Data_B;

  matrix_scan_scheduler #(
    .DIV_MAX     (3),
    .BLANK_TICKS (1),
    .SHOW_TICKS  (2),
    .COL_REVERSE (1'b0)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_rgb      (wr_rgb),
    .clr_req     (clr_req),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .COMM        (COMM),
    .E           (E),
    .Data_R      (Data_R),
    .Data_G      (Data_G),
    .Data_B      (Data_B)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;  // CLK edges since reset release

  // Expected displayed image and expected back-bank content, active-low per row.
  logic [7:0] disp_r [8], disp_g [8], disp_b [8];
  logic [7:0] pend_r [8], pend_g [8], pend_b [8];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic blank_model();
    for (int i = 0; i < 8; i++) begin
      disp_r[i] = 8'hFF; disp_g[i] = 8'hFF; disp_b[i] = 8'hFF;
      pend_r[i] = 8'hFF; pend_g[i] = 8'hFF; pend_b[i] = 8'hFF;
    end
  endtask

  // One CLK edge, then check everything the timing model predicts.
  task automatic step();
    logic       rq;
    logic       exp_e, exp_fs, exp_ack;
    logic [2:0] exp_row;
    logic [7:0] t;
    rq = swap_req;
    @(posedge CLK);
    #1;
    n++;
    exp_row = 3'((n / 12) % 8);
    exp_e   = (n % 12) >= 4;
    exp_fs  = (n % 96) == 0;
    exp_ack = exp_fs && rq;
    if (exp_ack) begin
      for (int i = 0; i < 8; i++) begin
        t = disp_r[i]; disp_r[i] = pend_r[i]; pend_r[i] = t;
        t = disp_g[i]; disp_g[i] = pend_g[i]; pend_g[i] = t;
        t = disp_b[i]; disp_b[i] = pend_b[i]; pend_b[i] = t;
      end
    end
    check("E", {7'd0, E}, {7'd0, exp_e});
    check("COMM", {5'd0, COMM}, {5'd0, exp_row});
    check("frame_start", {7'd0, frame_start}, {7'd0, exp_fs});
    check("swap_ack", {7'd0, swap_ack}, {7'd0, exp_ack});
    check("Data_R", Data_R, exp_e ? disp_r[exp_row] : 8'hFF);
    check("Data_G", Data_G, exp_e ? disp_g[exp_row] : 8'hFF);
    check("Data_B", Data_B, exp_e ? disp_b[exp_row] : 8'hFF);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic write_px(input logic [2:0] row, input logic [2:0] col, input logic [2:0] rgb);
    wr_en = 1'b1; wr_row = row; wr_col = col; wr_rgb = rgb;
    step();
    wr_en = 1'b0;
    pend_r[row][col] = ~rgb[2];
    pend_g[row][col] = ~rgb[1];
    pend_b[row][col] = ~rgb[0];
  endtask

  task automatic swap_at_boundary();
    swap_req = 1'b1;
    do step(); while ((n % 96) != 0);
    swap_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_R"}, Data_R, 8'hFF);
    check({tag, "_G"}, Data_G, 8'hFF);
    check({tag, "_B"}, Data_B, 8'hFF);
    check({tag, "_E"}, {7'd0, E}, 8'd0);
    check({tag, "_COMM"}, {5'd0, COMM}, 8'd0);
    check({tag, "_pulses"}, {6'd0, swap_ack, frame_start}, 8'd0);
  endtask

  initial begin
    blank_model();

    // Reset values while held, then release and free-run: timing, first E after 4 CLK.
    #23;
    check_reset_outputs("rst_hold");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    n = 0;
    run(100);

    // Single red pixel at (2,5), swapped in at the next frame boundary.
    write_px(3'd2, 3'd5, 3'b100);
    swap_at_boundary();
    run(100);

    // Dirty the back bank, then clear and write in the same cycle: clear wins.
    write_px(3'd0, 3'd0, 3'b111);
    write_px(3'd6, 3'd1, 3'b010);
    clr_req = 1'b1; wr_en = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_rgb = 3'b111;
    step();
    clr_req = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pend_r[i] = 8'hFF; pend_g[i] = 8'hFF; pend_b[i] = 8'hFF;
    end
    swap_at_boundary();

    // Request raised and dropped mid-frame: lost, image unchanged across the boundary.
    write_px(3'd3, 3'd3, 3'b001);
    run(5);
    swap_req = 1'b1;
    run(10);
    swap_req = 1'b0;
    run(150);

    // Real swap so the front bank holds an image before the reset case.
    swap_at_boundary();
    while (!(((n / 12) % 8) == 4 && (n % 12) == 6)) step();

    // Async reset during SHOW of row 4; both banks must come back blank.
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst_held2");
    RST_N = 1'b1;
    n = 0;
    blank_model();
    run(100);
    swap_at_boundary();
    run(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
